// File: rtl/midi_note_dco_ctrl_if.sv
// Byte stream in, DDS control out: the bus between the MIDI receiver, this parser and the oscillator.
interface midi_note_dco_ctrl_if;
  logic [7:0]  midi_byte;
  logic        midi_valid;
  logic [31:0] adder;
  logic        note_on;
  logic [6:0]  note;

  modport master (output midi_byte, midi_valid, input adder, note_on, note);
  modport slave  (input midi_byte, midi_valid, output adder, note_on, note);
endinterface

// File: rtl/midi_note_dco_ctrl.sv
// Monophonic MIDI Note On/Off parser with running status, driving a DDS phase increment and gate.
// Build macro MIDI_OMNI_EN: accept note messages on every channel and ignore MIDI_CH.
module midi_note_dco_ctrl #(
  parameter logic [3:0] MIDI_CH = 4'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  midi_note_dco_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NOTE = 2'd1;
  localparam logic [1:0] ST_VEL  = 2'd2;
  localparam logic [1:0] ST_SKIP = 2'd3;

  // Top-octave increments (notes 120..131) for a 390 625 Hz accumulator update rate.
  function automatic logic [31:0] tone_table(input logic [3:0] semi);
    case (semi)
      4'd0:    tone_table = 32'd92051312;
      4'd1:    tone_table = 32'd97524968;
      4'd2:    tone_table = 32'd103324105;
      4'd3:    tone_table = 32'd109468076;
      4'd4:    tone_table = 32'd115977386;
      4'd5:    tone_table = 32'd122873760;
      4'd6:    tone_table = 32'd130180214;
      4'd7:    tone_table = 32'd137921133;
      4'd8:    tone_table = 32'd146122350;
      4'd9:    tone_table = 32'd154811237;
      4'd10:   tone_table = 32'd164016792;
      4'd11:   tone_table = 32'd173769738;
      default: tone_table = 32'd0;
    endcase
  endfunction

  // note / 12 as a compare chain against the octave boundaries.
  function automatic logic [3:0] octave_of(input logic [6:0] n);
    octave_of = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      if (n >= 7'(12 * i)) octave_of = 4'(i);
    end
  endfunction

  function automatic logic [3:0] semitone_of(input logic [6:0] n, input logic [3:0] oct);
    semitone_of = 4'(n - 7'(oct) * 7'd12);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        run_on_q, run_on_d;
  logic [6:0]  pend_q, pend_d;
  logic [6:0]  note_q, note_d;
  logic        note_on_q, note_on_d;
  logic        upd_q, upd_d;
  logic        split_vld_q;
  logic [3:0]  oct_q, semi_q;
  logic [31:0] adder_q;

  logic [7:0]  byte_w;
  logic        is_note_status;
  logic        ch_ok;

  assign byte_w         = bus.midi_byte;
  assign is_note_status = (byte_w[7:5] == 3'b100);
`ifdef MIDI_OMNI_EN
  assign ch_ok = 1'b1;
`else
  assign ch_ok = (byte_w[3:0] == MIDI_CH);
`endif

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no branch can infer a latch.
    state_d   = state_q;
    run_on_d  = run_on_q;
    pend_d    = pend_q;
    note_d    = note_q;
    note_on_d = note_on_q;
    upd_d     = 1'b0;
    if (bus.midi_valid) begin
      if (byte_w[7]) begin
        // Real-time bytes (0xF8-0xFF) may interleave anywhere and leave the parser untouched.
        if (byte_w[7:3] != 5'b11111) begin
          if (byte_w[7:4] == 4'hF) begin
            state_d  = ST_IDLE;
            run_on_d = 1'b0;
          end else if (is_note_status && ch_ok) begin
            state_d  = ST_NOTE;
            run_on_d = byte_w[4];
          end else begin
            state_d  = ST_SKIP;
          end
        end
      end else begin
        case (state_q)
          ST_NOTE: begin
            pend_d  = byte_w[6:0];
            state_d = ST_VEL;
          end
          ST_VEL: begin
            state_d = ST_NOTE;
            if (run_on_q && (byte_w[6:0] != 7'd0)) begin
              note_d    = pend_q;
              note_on_d = 1'b1;
              upd_d     = 1'b1;
            end else if ((pend_q == note_q) && note_on_q) begin
              note_on_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments throughout, so each pipeline stage samples the pre-edge value
  //       of the stage before it and back-to-back notes stay in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_on_q    <= 1'b0;
      pend_q      <= 7'd0;
      note_q      <= 7'd0;
      note_on_q   <= 1'b0;
      upd_q       <= 1'b0;
      split_vld_q <= 1'b0;
      oct_q       <= 4'd0;
      semi_q      <= 4'd0;
      adder_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      run_on_q    <= run_on_d;
      pend_q      <= pend_d;
      note_q      <= note_d;
      note_on_q   <= note_on_d;
      upd_q       <= upd_d;
      split_vld_q <= upd_q;
      if (upd_q) begin
        oct_q  <= octave_of(note_q);
        semi_q <= semitone_of(note_q, octave_of(note_q));
      end
      if (split_vld_q) adder_q <= tone_table(semi_q) >> (4'd10 - oct_q);
    end
  end

  assign bus.adder   = adder_q;
  assign bus.note_on = note_on_q;
  assign bus.note    = note_q;

endmodule

// File: tb/tb_midi_note_dco_ctrl.sv
// Bench for midi_note_dco_ctrl: directed byte-sequence table, latency/reset sequences, random stream vs model.
module tb_midi_note_dco_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  midi_note_dco_ctrl_if bus ();

  midi_note_dco_ctrl #(.MIDI_CH(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MIDI_OMNI_EN
  localparam bit OMNI = 1'b1;
`else
  localparam bit OMNI = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Message-level reference: what a listener on channel 0 should conclude from the byte stream.
  int          m_type;    // 0 none, 8 Note Off, 9 Note On
  int          m_expect;  // 0 ignoring data, 1 waiting for note number, 2 waiting for velocity
  int          m_pend, m_note, m_on;
  logic [31:0] zl, zd1, zd2;  // zero-latency adder and its two-edge delay line

  function automatic logic [31:0] ref_adder(input int n);
    real f;
    int  tv;
    f  = 14080.0 * (2.0 ** ((real'(n % 12) - 9.0) / 12.0));
    tv = $rtoi(f * 4294967296.0 / 390625.0 + 0.5);
    return 32'(tv) >> (10 - n / 12);
  endfunction

  task automatic model_reset();
    m_type = 0; m_expect = 0; m_pend = 0; m_note = 0; m_on = 0;
    zl = '0; zd1 = '0; zd2 = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int hi;
    hi = int'(b[7:4]);
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_type = 0; m_expect = 0;
    end else if (b[7]) begin
      if ((hi == 8 || hi == 9) && (OMNI || b[3:0] == 4'd0)) begin
        m_type = hi; m_expect = 1;
      end else begin
        m_expect = 0;
      end
    end else if (m_expect == 1) begin
      m_pend = int'(b); m_expect = 2;
    end else if (m_expect == 2) begin
      m_expect = 1;
      if (m_type == 9 && b != 8'd0) begin
        m_note = m_pend; m_on = 1; zl = ref_adder(m_pend);
      end else if (m_pend == m_note && m_on == 1) begin
        m_on = 0;
      end
    end
  endtask

  // One clock: drive (valid, byte), advance model and DUT, optionally compare all outputs.
  task automatic tick(input logic v, input logic [7:0] b, input bit chk);
    logic [31:0] exp_adder;
    bus.midi_valid = v;
    bus.midi_byte  = b;
    if (v) model_byte(b);
    @(posedge clk);
    #1;
    exp_adder = zd2;
    zd2 = zd1;
    zd1 = zl;
    if (chk) begin
      check("rnd_note",    32'(bus.note),    32'(m_note));
      check("rnd_note_on", 32'(bus.note_on), 32'(m_on));
      check("rnd_adder",   bus.adder,        exp_adder);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    bus.midi_valid = 1'b0;
    bus.midi_byte  = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #3;
    check("rst_adder",   bus.adder,             32'd0);
    check("rst_note_on", 32'(bus.note_on),      32'd0);
    check("rst_note",    32'(bus.note),         32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input int note, input int on, input logic [31:0] adder);
    check({name, "_note"},    32'(bus.note),    32'(note));
    check({name, "_note_on"}, 32'(bus.note_on), 32'(on));
    check({name, "_adder"},   bus.adder,        adder);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b [10];
    int          note;
    int          on;
    logic [31:0] adder;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bus.midi_valid = 1'b0;
    bus.midi_byte  = 8'h00;
    model_reset();

    vecs[0]  = '{"on69",      3, '{0: 8'h90, 1: 8'h45, 2: 8'h64, default: 8'h00}, 69, 1, 32'd4837851};
    vecs[1]  = '{"running",   5, '{0: 8'h90, 1: 8'h3C, 2: 8'h40, 3: 8'h40, 4: 8'h40, default: 8'h00},
                 64, 1, 32'd3624293};
    vecs[2]  = '{"off_other", 6, '{0: 8'h90, 1: 8'h45, 2: 8'h64, 3: 8'h80, 4: 8'h3C, 5: 8'h00,
                 default: 8'h00}, 69, 1, 32'd4837851};
    vecs[3]  = '{"vel0_off",  9, '{0: 8'h90, 1: 8'h45, 2: 8'h64, 3: 8'h80, 4: 8'h3C, 5: 8'h00,
                 6: 8'h90, 7: 8'h45, 8: 8'h00, default: 8'h00}, 69, 0, 32'd4837851};
    vecs[4]  = '{"rt_inter",  5, '{0: 8'h90, 1: 8'hF8, 2: 8'h7F, 3: 8'hF8, 4: 8'h01, default: 8'h00},
                 127, 1, 32'd137921133};
`ifdef MIDI_OMNI_EN
    vecs[5]  = '{"other_ch",  3, '{0: 8'h91, 1: 8'h45, 2: 8'h64, default: 8'h00}, 69, 1, 32'd4837851};
`else
    vecs[5]  = '{"other_ch",  3, '{0: 8'h91, 1: 8'h45, 2: 8'h64, default: 8'h00}, 0, 0, 32'd0};
`endif
    vecs[6]  = '{"sys_common", 3, '{0: 8'hF0, 1: 8'h45, 2: 8'h64, default: 8'h00}, 0, 0, 32'd0};
    vecs[7]  = '{"on60",      3, '{0: 8'h90, 1: 8'h3C, 2: 8'h40, default: 8'h00}, 60, 1, 32'd2876603};
    vecs[8]  = '{"on0",       3, '{0: 8'h90, 1: 8'h00, 2: 8'h7F, default: 8'h00}, 0, 1, 32'd89893};
    vecs[9]  = '{"off_idle",  3, '{0: 8'h80, 1: 8'h45, 2: 8'h64, default: 8'h00}, 0, 0, 32'd0};
    vecs[10] = '{"skip_prog", 5, '{0: 8'hC0, 1: 8'h45, 2: 8'h90, 3: 8'h3C, 4: 8'h40, default: 8'h00},
                 60, 1, 32'd2876603};
    vecs[11] = '{"skip_cc",   6, '{0: 8'h90, 1: 8'h45, 2: 8'h64, 3: 8'hB0, 4: 8'h07, 5: 8'h64,
                 default: 8'h00}, 69, 1, 32'd4837851};

    for (int v = 0; v < 12; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) tick(1'b1, vecs[v].b[i], 1'b0);
      idle(3);
      expect_out(vecs[v].name, vecs[v].note, vecs[v].on, vecs[v].adder);
    end

    // Latency: note/gate at the velocity edge, adder exactly two edges later.
    do_reset();
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b1, 8'h45, 1'b0);
    tick(1'b1, 8'h64, 1'b0);
    expect_out("lat_e0", 69, 1, 32'd0);
    idle(1);
    check("lat_e1_adder", bus.adder, 32'd0);
    idle(1);
    check("lat_e2_adder", bus.adder, 32'd4837851);

    // Running status midway, then a retrigger while held.
    do_reset();
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h40, 1'b0);
    idle(3);
    expect_out("run_first", 60, 1, 32'd2876603);
    tick(1'b1, 8'h40, 1'b0);
    tick(1'b1, 8'h40, 1'b0);
    check("run_gate_held", 32'(bus.note_on), 32'd1);
    idle(3);
    expect_out("run_second", 64, 1, 32'd3624293);

    // Reset between note number and velocity: everything cleared, trailing velocity ignored.
    do_reset();
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b1, 8'h45, 1'b0);
    tick(1'b1, 8'h64, 1'b0);
    idle(3);
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b1, 8'h45, 1'b0);
    bus.midi_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    expect_out("rst_mid_msg", 0, 0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 8'h64, 1'b0);
    idle(3);
    expect_out("rst_trailing", 0, 0, 32'd0);

    // Reset while a conversion is in flight: no adder update after release.
    do_reset();
    tick(1'b1, 8'h90, 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h40, 1'b0);
    bus.midi_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    idle(4);
    expect_out("rst_mid_pipe", 0, 0, 32'd0);

    // Random stream, every cycle compared against the message-level model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int         r;
      logic [7:0] b;
      logic [3:0] ch;
      r  = int'($urandom_range(0, 99));
      ch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (r < 20) begin
        tick(1'b0, 8'h00, 1'b1);
      end else begin
        if (r < 28)      b = {4'h9, ch};
        else if (r < 34) b = {4'h8, ch};
        else if (r < 36) b = 8'($urandom_range(8'hF8, 8'hFF));
        else if (r < 37) b = 8'($urandom_range(8'hF0, 8'hF7));
        else if (r < 39) b = 8'($urandom_range(8'hA0, 8'hEF));
        else if (r < 48) b = 8'h00;
        else             b = 8'($urandom_range(0, 127));
        tick(1'b1, b, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_note_dco_ctrl.md
# midi_note_dco_ctrl

Monophonic MIDI-to-DDS control stage. Consumes a byte stream from the MIDI UART receiver, parses Note On / Note Off for one channel with running status, and drives the `adder` (32-bit DDS phase increment) and `note_on` inputs of the I2S DDS oscillator directly downstream. The note-to-increment conversion uses a 12-entry top-octave table plus a right shift, sized for the oscillator's 390 625 Hz accumulator update rate (50 MHz clock, LR_BIT = 7).

## Interface
- `MIDI_CH`, 4'd0: MIDI channel (0-15) to respond to.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `midi_byte`  in  8  received MIDI byte; valid only with `midi_valid`.
- `midi_valid`  in  1  one-cycle strobe; one byte per strobe; strobes may arrive on consecutive cycles.
- `adder`  out  32  DDS phase increment for the current note.
- `note_on`  out  1  gate; high while a note is held.
- `note`  out  7  current or last MIDI note number.

## Operation
- Byte classes:
  - status: bit7 = 1.
  - real-time: 0xF8-0xFF.
  - system common: 0xF0-0xF7.
  - data: bit7 = 0.
- Parser FSM states: IDLE, NOTE, VEL, SKIP.
- Transitions on `midi_valid`:
  - Real-time byte: ignored in any state; no state change.
  - 0x8n or 0x9n with n = `MIDI_CH`: store the status as the running type, go to NOTE.
  - Any other channel status, or 0x8n/0x9n on another channel: go to SKIP.
  - System common: clear running status, go to IDLE.
  - Data byte in IDLE or SKIP: ignored.
  - Data byte in NOTE: latch as the pending note, go to VEL.
  - Data byte in VEL: message complete, go to NOTE (running status).
- Message completion:
  - Note On with velocity > 0: `note` ← pending note, `note_on` ← 1, `adder` recomputed.
  - Note Off (0x8n), or Note On with velocity 0: if pending note == `note` and `note_on` = 1, then `note_on` ← 0. Otherwise no effect.
  - `adder` and `note` are held when a note is released.
- Priority: the last Note On wins. A retrigger while a note is held updates `note` and `adder`; `note_on` stays 1.
- Conversion: octave o = note / 12, semitone s = note % 12.
  - `adder` = TABLE[s] >> (10 − o).
  - TABLE[s] = round(f(120+s) · 2³² / 390625), where f(120) = 8372.018 Hz, equal temperament, A9 = 14080 Hz.
  - Example: TABLE[9] = 154811237.
  - The shift truncates. o ranges 0-10; note 127 gives o = 10, s = 7, shift 0.
  - The /12 and %12 are implemented without a divider (compare/subtract chain or lookup).

## Timing
- Reset values:
  - `adder` = 0, `note_on` = 0, `note` = 0.
  - FSM = IDLE, running status cleared, pending note = 0.
- Latency: the `midi_valid` cycle carrying the completing velocity byte is cycle 0.
  - `note` and `note_on` update at the clock edge ending cycle 0.
  - `adder` updates at the edge ending cycle 2 (two register stages: octave/semitone split, then table + shift).
- `note_on` for a Note On therefore rises 2 cycles before the new `adder`. This is acceptable because the oscillator samples at ≥ 128-clock intervals.
- Back-to-back messages: the conversion pipeline accepts a new note every cycle; each completion yields its own `adder` 2 cycles later, in order.
- Reset asserted mid-message or mid-pipeline: all state returns to reset values immediately. No `adder` update follows deassertion.

## Configuration
- `MIDI_OMNI_EN`
  - Defined: Note On/Off on any channel is accepted, and `MIDI_CH` is ignored.
  - Undefined: only `MIDI_CH` is accepted; other channels go to SKIP.

## Test plan
- Reset, then bytes 0x90, 0x45, 0x64 (`MIDI_CH` = 0):
  - `note` = 69 and `note_on` = 1 one cycle later.
  - `adder` = 4837851 three edges after the velocity byte.
- Running status: 0x90, 0x3C, 0x40, 0x40, 0x40:
  - First pair: note 60, `adder` = TABLE[0] >> 5.
  - Second pair: note 64, `adder` = TABLE[4] >> 5.
  - `note_on` stays 1 throughout.
- Note 69 held, then 0x80, 0x3C, 0x00: `note_on` stays 1. Then 0x90, 0x45, 0x00: `note_on` → 0, `adder` still 4837851.
- 0xF8 inserted between every byte of 0x90, 0x7F, 0x01: same result as without it; `note` = 127, `adder` = TABLE[7].
- 0x91, 0x45, 0x64 with `MIDI_CH` = 0: no output change without `MIDI_OMNI_EN`; `note_on` = 1 with it. Then 0xF0, 0x45, 0x64: ignored in both builds.
- `rst_n` pulsed low between the 0x45 and 0x64 bytes: all outputs 0 and a trailing 0x64 is ignored.
